portal_word_gather: RTL



---
 rtl/portal_word_gather_pkg.sv | 29 ++
 rtl/portal_word_gather_counter.sv | 22 ++
 rtl/portal_word_gather.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/portal_word_gather_pkg.sv
// Shared types and constants for the P2M word gatherer: message layout,
// header field positions and the gatherer state encoding.
package portal_word_gather_pkg;

  localparam int NOC_DATA_W    = 128;
  localparam int NOC_LEN_W     = 16;
  localparam int MSG_MAX_WORDS = 4;
  localparam int MAX_PAYLOAD   = MSG_MAX_WORDS - 1;
  localparam int SLOT_W        = 2;

  // Header word: [31:16] method id, [15:0] payload word count.
  localparam int HDR_ID_MSB  = 31;
  localparam int HDR_ID_LSB  = 16;
  localparam int HDR_CNT_MSB = 15;

  // Packed so that data occupies [143:16] and length [15:0] of the flat vector.
  typedef struct packed {
    logic [NOC_DATA_W-1:0] data;
    logic [NOC_LEN_W-1:0]  length;
  } NOCDataH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } gather_state_e;

endpackage

// File: rtl/portal_word_gather_counter.sv
// Free-running statistics counter: increments on inc, wraps at 2^CNT_W.
module portal_word_gather_counter
  import portal_word_gather_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count events; plain modular add, no saturation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (inc) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/portal_word_gather.sv
// Gathers a header word plus up to three payload words from the host word
// stream into one NOCDataH message for the P2M demux; malformed messages
// (payload count above three) are consumed silently and counted.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a header word
// COLLECT | storing payload words, rem words still to come
// DISCARD | swallowing the payload of a malformed message
// HOLD    | complete message buffered, offering it downstream
module portal_word_gather
  import portal_word_gather_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int MAX_WORDS = 4,
  parameter int CNT_W     = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_enq__ENA,
  input  logic [WORD_W-1:0]     in_enq_v,
  output logic                  in_enq__RDY,
  output logic                  out_enq__ENA,
  output logic [NOC_DATA_W+NOC_LEN_W-1:0] out_enq_v,
  input  logic                  out_enq__RDY,
  output logic [CNT_W-1:0]      msg_count,
  output logic [CNT_W-1:0]      err_count
);

  gather_state_e state_q, state_d;
  logic [HDR_CNT_MSB:0] rem_q, rem_d;
  logic [SLOT_W-1:0]    n_q, n_d;
  NOCDataH              msg_q;

  logic [HDR_CNT_MSB:0] hdr_cnt;
  logic [SLOT_W-1:0]    slot;
  logic                 load_hdr;
  logic                 load_word;
  logic                 msg_inc;
  logic                 err_inc;

  assign hdr_cnt = in_enq_v[HDR_CNT_MSB:0];
  // Payload slot for the word being accepted: words already received.
  assign slot    = n_q - rem_q[SLOT_W-1:0];

  // State, remaining-word counter and stored payload count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      rem_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      n_q     <= n_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    n_d          = n_q;
    load_hdr     = 1'b0;
    load_word    = 1'b0;
    msg_inc      = 1'b0;
    err_inc      = 1'b0;
    in_enq__RDY  = 1'b1;
    out_enq__ENA = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_enq__ENA) begin
          if (hdr_cnt == '0) begin
            load_hdr = 1'b1;
            state_d  = HOLD;
          end else if (hdr_cnt <= 16'(MAX_WORDS - 1)) begin
            load_hdr = 1'b1;
            rem_d    = hdr_cnt;
            n_d      = hdr_cnt[SLOT_W-1:0];
            state_d  = COLLECT;
          end else begin
            rem_d    = hdr_cnt;
            err_inc  = 1'b1;
            state_d  = DISCARD;
          end
        end
      end
      COLLECT: begin
        if (in_enq__ENA) begin
          load_word = 1'b1;
          rem_d     = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = HOLD;
          end
        end
      end
      DISCARD: begin
        if (in_enq__ENA) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        // Source is stalled here, so any stray in_enq__ENA is ignored.
        in_enq__RDY  = 1'b0;
        out_enq__ENA = out_enq__RDY;
        if (out_enq__RDY) begin
          msg_inc = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Message register: header clears the payload slots, payload words fill them in order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      msg_q <= '0;
    end else if (load_hdr) begin
      msg_q.data   <= {in_enq_v[HDR_ID_MSB:HDR_ID_LSB], in_enq_v[HDR_CNT_MSB:0],
                       {(MAX_PAYLOAD*WORD_W){1'b0}}};
      msg_q.length <= hdr_cnt + 16'd1;
    end else if (load_word) begin
      case (slot)
        2'd0:    msg_q.data[2*WORD_W +: WORD_W] <= in_enq_v;
        2'd1:    msg_q.data[1*WORD_W +: WORD_W] <= in_enq_v;
        default: msg_q.data[0 +: WORD_W]        <= in_enq_v;
      endcase
    end
  end

  assign out_enq_v = msg_q;

  portal_word_gather_counter #(.CNT_W(CNT_W)) u_msg_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (msg_inc),
    .count (msg_count)
  );

  portal_word_gather_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule
